// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU (A) and load (B) writeback queues onto the single regfile write port, with RAW hazard flags.
// Defining REGFILE_ARB_BYPASS_EN adds fwd_valid1/2 and fwd_data1/2, which forward the youngest pending write.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [AW-1:0]          a_reg,
  input  logic [DW-1:0]          a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [AW-1:0]          b_reg,
  input  logic [DW-1:0]          b_data,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_reg,
  output logic [DW-1:0]          wr_data,
  input  logic [AW-1:0]          rd_reg1,
  input  logic [AW-1:0]          rd_reg2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic [$clog2(DEPTH):0] a_level,
  output logic [$clog2(DEPTH):0] b_level
`ifdef REGFILE_ARB_BYPASS_EN
  ,
  output logic                   fwd_valid1,
  output logic                   fwd_valid2,
  output logic [DW-1:0]          fwd_data1,
  output logic [DW-1:0]          fwd_data2
`endif
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_e;

  // Index 0 is requester A, index 1 is requester B throughout.
  logic          in_vld [2];
  logic [AW-1:0] in_reg [2];
  logic [DW-1:0] in_dat [2];
  logic [AW-1:0] mem_reg_q [2][DEPTH];
  logic [DW-1:0] mem_dat_q [2][DEPTH];
  logic [PW-1:0] wp_q [2];
  logic [PW-1:0] rp_q [2];
  logic [PW-1:0] wp_d [2];
  logic [PW-1:0] rp_d [2];
  logic [PW-1:0] lvl [2];
  logic          full [2];
  logic          empty [2];
  logic          push [2];
  logic          pop [2];
  rr_e           rr_q, rr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_reg_q, wr_reg_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  assign in_vld[0] = a_valid;
  assign in_vld[1] = b_valid;
  assign in_reg[0] = a_reg;
  assign in_reg[1] = b_reg;
  assign in_dat[0] = a_data;
  assign in_dat[1] = b_data;

  // Writes to r0 complete the handshake but never occupy a slot.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      empty[q] = (wp_q[q] == rp_q[q]);
      full[q]  = (wp_q[q][PW-1] != rp_q[q][PW-1]) && (wp_q[q][IW-1:0] == rp_q[q][IW-1:0]);
      lvl[q]   = wp_q[q] - rp_q[q];
      push[q]  = in_vld[q] && !full[q] && (in_reg[q] != '0);
    end
  end

  always_comb begin
    pop[0]    = !empty[0] && (empty[1] || rr_q == RR_A);
    pop[1]    = !empty[1] && (empty[0] || rr_q == RR_B);
    rr_d      = rr_q;
    wr_en_d   = pop[0] || pop[1];
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    for (int q = 0; q < 2; q++) begin
      wp_d[q] = wp_q[q] + PW'(push[q]);
      rp_d[q] = rp_q[q] + PW'(pop[q]);
    end
    if (pop[0]) begin
      rr_d      = RR_B;
      wr_reg_d  = mem_reg_q[0][rp_q[0][IW-1:0]];
      wr_data_d = mem_dat_q[0][rp_q[0][IW-1:0]];
    end else if (pop[1]) begin
      rr_d      = RR_A;
      wr_reg_d  = mem_reg_q[1][rp_q[1][IW-1:0]];
      wr_data_d = mem_dat_q[1][rp_q[1][IW-1:0]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q      <= RR_A;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      for (int q = 0; q < 2; q++) begin
        wp_q[q] <= '0;
        rp_q[q] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      for (int q = 0; q < 2; q++) begin
        wp_q[q] <= wp_d[q];
        rp_q[q] <= rp_d[q];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int q = 0; q < 2; q++) begin
      if (push[q]) begin
        mem_reg_q[q][wp_q[q][IW-1:0]] <= in_reg[q];
        mem_dat_q[q][wp_q[q][IW-1:0]] <= in_dat[q];
      end
    end
  end

  assign a_ready = !full[0];
  assign b_ready = !full[1];
  assign a_level = lvl[0];
  assign b_level = lvl[1];
  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;

  logic [AW-1:0] rd [2];
  logic          qhit [2][2];
  logic          shit [2];
  logic [IW-1:0] idx;
`ifdef REGFILE_ARB_BYPASS_EN
  logic [DW-1:0] qdat [2][2];
`endif

  assign rd[0] = rd_reg1;
  assign rd[1] = rd_reg2;

  // Walk each queue oldest to youngest so the last match seen is the youngest.
  always_comb begin
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      for (int q = 0; q < 2; q++) begin
        qhit[p][q] = 1'b0;
`ifdef REGFILE_ARB_BYPASS_EN
        qdat[p][q] = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
          idx = rp_q[q][IW-1:0] + IW'(k);
          if (PW'(k) < lvl[q] && mem_reg_q[q][idx] == rd[p]) begin
            qhit[p][q] = 1'b1;
`ifdef REGFILE_ARB_BYPASS_EN
            qdat[p][q] = mem_dat_q[q][idx];
`endif
          end
        end
      end
      shit[p] = wr_en_q && (wr_reg_q == rd[p]);
    end
  end

  assign hazard1 = (rd_reg1 != '0) && (qhit[0][0] || qhit[0][1] || shit[0]);
  assign hazard2 = (rd_reg2 != '0) && (qhit[1][0] || qhit[1][1] || shit[1]);

`ifdef REGFILE_ARB_BYPASS_EN
  logic          fv [2];
  logic [DW-1:0] fd [2];

  // Matches in both queues have no defined youngest, so forwarding is withheld.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fv[p] = 1'b0;
      fd[p] = '0;
      if (rd[p] != '0 && !(qhit[p][0] && qhit[p][1])) begin
        if (qhit[p][0]) begin
          fv[p] = 1'b1;
          fd[p] = qdat[p][0];
        end else if (qhit[p][1]) begin
          fv[p] = 1'b1;
          fd[p] = qdat[p][1];
        end else if (shit[p]) begin
          fv[p] = 1'b1;
          fd[p] = wr_data_q;
        end
      end
    end
  end

  assign fwd_valid1 = fv[0];
  assign fwd_valid2 = fv[1];
  assign fwd_data1  = fd[0];
  assign fwd_data2  = fd[1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter; expected write orders and flags are hand-derived.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_reg = '0, b_reg = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_reg1 = '0, rd_reg2 = '0;
  logic          hazard1, hazard2;
  logic [2:0]    a_level, b_level;
`ifdef REGFILE_ARB_BYPASS_EN
  logic          fwd_valid1, fwd_valid2;
  logic [DW-1:0] fwd_data1, fwd_data2;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [AW-1:0] log_reg [$];
  logic [DW-1:0] log_dat [$];
  logic [AW-1:0] sa_reg [16];
  logic [DW-1:0] sa_dat [16];
  logic [AW-1:0] sb_reg [16];
  logic [DW-1:0] sb_dat [16];
  bit            b_full_seen;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard1(hazard1), .hazard2(hazard2),
    .a_level(a_level), .b_level(b_level)
`ifdef REGFILE_ARB_BYPASS_EN
    , .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && wr_en) begin
      log_reg.push_back(wr_reg);
      log_dat.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0; rd_reg1 = '0; rd_reg2 = '0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    log_reg.delete();
    log_dat.delete();
  endtask

  task automatic drive(input int na, input int nb);
    int  ai = 0;
    int  bi = 0;
    bit  ra, rb;
    for (int c = 0; c < 200 && (ai < na || bi < nb); c++) begin
      a_valid = (ai < na);
      b_valid = (bi < nb);
      if (ai < na) begin a_reg = sa_reg[ai]; a_data = sa_dat[ai]; end
      if (bi < nb) begin b_reg = sb_reg[bi]; b_data = sb_dat[bi]; end
      #1;
      ra = a_valid && a_ready;
      rb = b_valid && b_ready;
      if (b_level == 3'(DEPTH) && !b_ready) b_full_seen = 1'b1;
      @(negedge clock);
      if (ra) ai++;
      if (rb) bi++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("drive_all_accepted", 32'((ai == na) && (bi == nb)), 32'd1);
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 60; c++) begin
      if (a_level == 0 && b_level == 0 && !wr_en) break;
      @(negedge clock);
    end
    check("drain_timeout", 32'(c < 60), 32'd1);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int ia, ib;

    // Reset state while reset is still high.
    @(negedge clock);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_reg", wr_reg, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    check("rst_a_level", a_level, 0);
    check("rst_b_level", b_level, 0);
    check("rst_hazard1", hazard1, 0);

    // 1: single write latency and hazard lifetime.
    do_reset();
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1111_1111; rd_reg1 = 5'd5;
    #1;
    check("t1_a_ready", a_ready, 1);
    check("t1_hz_before", hazard1, 0);
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    check("t1_level", a_level, 1);
    check("t1_hz_queued", hazard1, 1);
    check("t1_wr_en_early", wr_en, 0);
    @(negedge clock);
    #1;
    check("t1_wr_en", wr_en, 1);
    check("t1_wr_reg", wr_reg, 5);
    check("t1_wr_data", wr_data, 32'h1111_1111);
    check("t1_hz_stage", hazard1, 1);
    @(negedge clock);
    #1;
    check("t1_wr_en_off", wr_en, 0);
    check("t1_hz_clear", hazard1, 0);
    check("t1_wr_reg_hold", wr_reg, 5);

    // 2: continuous contention alternates A,B starting with A.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sa_reg[i] = 5'(1 + i);  sa_dat[i] = 32'h0A00 + 32'(i);
      sb_reg[i] = 5'(11 + i); sb_dat[i] = 32'h0B00 + 32'(i);
    end
    drive(4, 4);
    wait_idle();
    check("t2_count", log_reg.size(), 8);
    for (int i = 0; i < 8 && i < log_reg.size(); i++) begin
      check($sformatf("t2_reg%0d", i), log_reg[i], (i % 2 == 0) ? 32'(1 + i / 2) : 32'(11 + i / 2));
      check($sformatf("t2_dat%0d", i), log_dat[i],
            (i % 2 == 0) ? 32'h0A00 + 32'(i / 2) : 32'h0B00 + 32'(i / 2));
    end

    // 3: B fills under flood, nothing lost, FIFO order kept per queue.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sa_reg[i] = 5'(1 + i);  sa_dat[i] = 32'h1000 + 32'(i);
      sb_reg[i] = 5'(16 + i); sb_dat[i] = 32'h2000 + 32'(i);
    end
    b_full_seen = 1'b0;
    drive(8, 8);
    wait_idle();
    check("t3_b_full_seen", 32'(b_full_seen), 1);
    check("t3_count", log_reg.size(), 16);
    ia = 0;
    ib = 0;
    foreach (log_reg[i]) begin
      if (log_reg[i] < 5'd16) begin
        check($sformatf("t3_a%0d", ia), {log_reg[i], log_dat[i][26:0]}, {5'(1 + ia), 27'(32'h1000 + 32'(ia))});
        ia++;
      end else begin
        check($sformatf("t3_b%0d", ib), {log_reg[i], log_dat[i][26:0]}, {5'(16 + ib), 27'(32'h2000 + 32'(ib))});
        ib++;
      end
    end

    // 4: r0 writes are accepted and dropped.
    do_reset();
    a_valid = 1'b1; a_reg = '0; a_data = 32'hDEAD_BEEF; rd_reg1 = '0;
    #1;
    check("t4_a_ready", a_ready, 1);
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    check("t4_level", a_level, 0);
    check("t4_hazard1", hazard1, 0);
    repeat (3) @(negedge clock);
    #2;
    check("t4_no_write", log_reg.size(), 0);

    // 5: reset mid-drain, then arbitration restarts at A.
    do_reset();
    a_valid = 1'b1; a_reg = 5'd2;  a_data = 32'h22;
    b_valid = 1'b1; b_reg = 5'd20; b_data = 32'h200;
    @(negedge clock);
    a_reg = 5'd3;  a_data = 32'h33;
    b_reg = 5'd21; b_data = 32'h210;
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0; rd_reg2 = 5'd21;
    #1;
    check("t5_pre_wr_en", wr_en, 1);
    check("t5_pre_hz2", hazard2, 1);
    check("t5_pre_blvl", b_level, 2);
    reset = 1'b1;
    #1;
    check("t5_rst_wr_en", wr_en, 0);
    check("t5_rst_wr_reg", wr_reg, 0);
    check("t5_rst_alvl", a_level, 0);
    check("t5_rst_blvl", b_level, 0);
    check("t5_rst_hz2", hazard2, 0);
    check("t5_rst_b_ready", b_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    log_reg.delete();
    log_dat.delete();
    a_valid = 1'b1; a_reg = 5'd9;  a_data = 32'h99;
    b_valid = 1'b1; b_reg = 5'd19; b_data = 32'h190;
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_idle();
    check("t5_count", log_reg.size(), 2);
    if (log_reg.size() >= 2) begin
      check("t5_first", log_reg[0], 9);
      check("t5_second", log_reg[1], 19);
    end

`ifdef REGFILE_ARB_BYPASS_EN
    // 6: forwarding picks the youngest write; matches in both queues stall.
    do_reset();
    #1;
    check("t6_rst_fv1", fwd_valid1, 0);
    check("t6_rst_fd1", fwd_data1, 0);
    rd_reg1 = 5'd7;
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h10;
    b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h3;
    @(negedge clock);
    a_data = 32'h20;
    b_valid = 1'b0;
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    check("t6_fv1", fwd_valid1, 1);
    check("t6_fd1", fwd_data1, 32'h20);
    check("t6_hz1", hazard1, 1);
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h30;
    @(negedge clock);
    b_valid = 1'b0;
    #1;
    check("t6_amb_fv1", fwd_valid1, 0);
    check("t6_amb_fd1", fwd_data1, 0);
    check("t6_amb_hz1", hazard1, 1);
    wait_idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
